lbdr_dr: RTL and testbench
==========================

LBDR_DR -- requirements
Module: lbdr_dr

Interface
REQ-001 Parameter XW, default 2: destination/current X coordinate width in bits.
REQ-002 Parameter YW, default 2: Y coordinate width in bits; address = {y, x}, total AW = XW+YW.
REQ-003 Parameter RXY_RST, default 8'h3C: reset routing bits, bit0..7 = Rne, Rnw, Ren, Res, Rwn, Rws, Rse, Rsw.
REQ-004 Parameter CX_RST, default 4'hF: reset connectivity bits, bit0..3 = Cn, Ce, Cw, Cs.
REQ-005 Parameter CUR_RST, default AW'd5: reset current router address.
REQ-006 Parameter DR_RST, default 4'b0000: reset deroute port, one-hot {S,W,E,N}; zero means no deroute.
REQ-007 Parameters HDR=3'b001, PLD=3'b010, TL=3'b100: flit_id encodings.
REQ-008 Reset rst, synchronous, active-high; clock clk.
REQ-009 clk  in  1  rising-edge clock.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 cfg_we  in  1  config write request, held by the requester until cfg_ack.
REQ-012 cfg_rxy  in  8  new routing bits.
REQ-013 cfg_cx  in  4  new connectivity bits.
REQ-014 cfg_cur  in  AW  new current address.
REQ-015 cfg_dr  in  4  new deroute port.
REQ-016 cfg_ack  out  1  one-cycle pulse: config applied.
REQ-017 in_valid  in  1  flit present.
REQ-018 in_ready  out  1  flit accepted when in_valid & in_ready.
REQ-019 flit_id  in  3  flit type.
REQ-020 dst_addr  in  AW  destination; sampled on header only.
REQ-021 port_req  out  5  candidate output set {L,S,W,E,N}, held for the whole packet.
REQ-022 route_valid  out  1  port_req is valid for the current packet.
REQ-023 route_err  out  1  one-cycle pulse: header unroutable.
REQ-024 proto_err  out  1  one-cycle pulse: flit type illegal in the current state.

Function
REQ-025 Comparators: N1 = y_dst<y_cur; S1 = y_cur<y_dst; E1 = x_cur<x_dst; W1 = x_dst<x_cur; all unsigned at full XW/YW width.
REQ-026 Minimal set: N = (N1&~E1&~W1 | N1&E1&Rne | N1&W1&Rnw)&Cn; E = (E1&~N1&~S1 | E1&N1&Ren | E1&S1&Res)&Ce; W and S are symmetric using Rwn/Rws/Cw and Rse/Rsw/Cs; L = ~N1&~E1&~W1&~S1.
REQ-027 Deroute: if the minimal set is empty and L=0, the set is Dr & Cx; if that is also empty, the header is unroutable.
REQ-028 FSM states are IDLE, ROUTED and DROP.
REQ-029 IDLE, accepted HDR, routable: port_req = set and route_valid=1 from cycle t+1; next state ROUTED.
REQ-030 IDLE, accepted HDR, unroutable: port_req=0, route_valid=0, route_err=1 at t+1; next state DROP.
REQ-031 ROUTED, accepted PLD: port_req and route_valid are unchanged.
REQ-032 ROUTED, accepted TL: port_req and route_valid are held during the TL cycle and cleared at t+1; next state IDLE.
REQ-033 ROUTED, accepted HDR: the previous packet is truncated, proto_err=1, the header is recomputed as in IDLE, and the next state is ROUTED or DROP.
REQ-034 DROP: PLD is consumed silently; TL is consumed and the next state is IDLE; HDR is handled as in REQ-033.
REQ-035 IDLE, accepted PLD or TL: the flit is discarded, proto_err=1 at t+1, and the state stays IDLE.
REQ-036 flit_id not in {HDR, PLD, TL}: the flit is accepted and ignored, with proto_err=1 and no state change.
REQ-037 in_ready=1 in all states except IDLE with cfg_we=1.
REQ-038 Config: applied only in IDLE with no flit accepted that cycle; registers update at t+1 and cfg_ack=1 at t+1; cfg_we in ROUTED or DROP waits.
REQ-039 A packet in flight always keeps its header-time routing; a later config change never alters its port_req.
REQ-040 All outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-041 On rst: Rxy=RXY_RST, Cx=CX_RST, cur=CUR_RST, Dr=DR_RST, state=IDLE, port_req=0, route_valid=0, all pulses=0.
REQ-042 rst mid-packet abandons the packet; the following PLD or TL produces a proto_err per REQ-035.
REQ-043 rst overrides cfg_we and in_valid in the same cycle.

Verification
REQ-044 Defaults, HDR dst=0, then PLD, then TL -> port_req=5'b00100 (W) from t+1 through the TL cycle, 0 after.
REQ-045 Defaults, HDR dst=5 -> port_req=5'b10000 (L), route_valid=1.
REQ-046 cfg cx=4'b1011, dr=4'b0001, then HDR dst=4 -> port_req=5'b00001 (N, deroute); same with dr=0 -> route_err pulse, PLD/TL dropped, then IDLE.
REQ-047 cfg_we asserted during ROUTED -> no cfg_ack until one cycle after TL; the packet keeps its original port_req.
REQ-048 PLD in IDLE, then HDR during ROUTED -> proto_err each time; the second header's route is used.
REQ-049 XW=YW=3, cur=9'd..., e.g. cur={3'd3,3'd3}, dst={3'd7,3'd0} -> S1&W1; with Rsw=0 and Rws=1 -> port_req=5'b00100.

Source files
------------

// File: rtl/lbdr_dr.sv
// rtl/lbdr_dr.sv - LBDR routing unit with deroute fallback and per-packet route hold
//
// Computes the candidate output port set for each packet header from the router's
// routing bits (Rxy), connectivity bits (Cx), current address and deroute port.
// The set is latched at header time and held until the tail flit is accepted.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   cfg_we        config write request, held until cfg_ack
//   cfg_rxy       new routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//   cfg_cx        new connectivity bits {Cs,Cw,Ce,Cn}
//   cfg_cur       new current router address {y,x}
//   cfg_dr        new deroute port, one-hot {S,W,E,N}
//   cfg_ack       one-cycle pulse, config applied
//   in_valid      flit present
//   in_ready      flit accepted when in_valid & in_ready
//   flit_id       flit type (HDR/PLD/TL)
//   dst_addr      destination {y,x}, sampled on headers only
//   port_req      candidate outputs {L,S,W,E,N}, held for the packet
//   route_valid   port_req valid for the current packet
//   route_err     one-cycle pulse, header unroutable
//   proto_err     one-cycle pulse, flit type illegal in current state

module lbdr_dr #(
   parameter int               XW      = 2,
   parameter int               YW      = 2,
   parameter logic [7:0]       RXY_RST = 8'h3C,
   parameter logic [3:0]       CX_RST  = 4'hF,
   parameter logic [XW+YW-1:0] CUR_RST = (XW+YW)'(5),
   parameter logic [3:0]       DR_RST  = 4'b0000,
   parameter logic [2:0]       HDR     = 3'b001,
   parameter logic [2:0]       PLD     = 3'b010,
   parameter logic [2:0]       TL      = 3'b100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [7:0]       cfg_rxy,
   input  logic [3:0]       cfg_cx,
   input  logic [XW+YW-1:0] cfg_cur,
   input  logic [3:0]       cfg_dr,
   output logic             cfg_ack,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       flit_id,
   input  logic [XW+YW-1:0] dst_addr,
   output logic [4:0]       port_req,
   output logic             route_valid,
   output logic             route_err,
   output logic             proto_err
);

   typedef enum logic [1:0] {IDLE, ROUTED, DROP} state_t;

   state_t             state;
   logic [7:0]         rxy;
   logic [3:0]         cx;
   logic [XW+YW-1:0]   cur;
   logic [3:0]         dr;

   logic [XW-1:0]      x_dst, x_cur;
   logic [YW-1:0]      y_dst, y_cur;
   logic               n1, s1, e1, w1;
   logic               go_n, go_e, go_w, go_s, go_l;
   logic [4:0]         route_set;
   logic               routable;

   logic               accept;
   logic               nxt_idle;
   logic               cfg_apply;

   // Route computation for the header on the input right now, using the
   // configuration currently in force.
   always_comb begin
      x_dst = dst_addr[XW-1:0];
      y_dst = dst_addr[XW+YW-1:XW];
      x_cur = cur[XW-1:0];
      y_cur = cur[XW+YW-1:XW];

      n1 = y_dst < y_cur;
      s1 = y_cur < y_dst;
      e1 = x_cur < x_dst;
      w1 = x_dst < x_cur;

      go_n = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
      go_e = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
      go_w = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
      go_s = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];
      go_l = ~n1 & ~e1 & ~w1 & ~s1;

      route_set = 5'b00000;
      if (go_l)
         route_set = 5'b10000;
      else if (go_n | go_e | go_w | go_s)
         route_set = {1'b0, go_s, go_w, go_e, go_n};
      else
         // Dr and Cx share the {S,W,E,N} bit order, so a plain AND lines up.
         route_set = {1'b0, dr & cx};
      routable = route_set != 5'b00000;
   end

   always_comb begin
      accept   = in_valid & in_ready;
      nxt_idle = state == IDLE;
      if (accept) begin
         if (flit_id == TL)
            nxt_idle = 1'b1;
         else if (flit_id == HDR)
            nxt_idle = 1'b0;
      end
      // cfg_ack high means this request was just served; the requester is
      // still holding cfg_we only because it has not yet seen the ack.
      cfg_apply = (state == IDLE) & cfg_we & ~accept & ~cfg_ack;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rxy         <= RXY_RST;
         cx          <= CX_RST;
         cur         <= CUR_RST;
         dr          <= DR_RST;
         port_req    <= 5'b00000;
         route_valid <= 1'b0;
         route_err   <= 1'b0;
         proto_err   <= 1'b0;
         cfg_ack     <= 1'b0;
         in_ready    <= 1'b1;
      end else begin
         route_err <= 1'b0;
         proto_err <= 1'b0;
         cfg_ack   <= 1'b0;

         if (accept) begin
            if (flit_id == HDR) begin
               // A header outside IDLE truncates whatever packet was open.
               if (state != IDLE)
                  proto_err <= 1'b1;
               if (routable) begin
                  port_req    <= route_set;
                  route_valid <= 1'b1;
                  state       <= ROUTED;
               end else begin
                  port_req    <= 5'b00000;
                  route_valid <= 1'b0;
                  route_err   <= 1'b1;
                  state       <= DROP;
               end
            end else if (flit_id == PLD) begin
               if (state == IDLE)
                  proto_err <= 1'b1;
            end else if (flit_id == TL) begin
               case (state)
                  IDLE:    proto_err <= 1'b1;
                  ROUTED: begin
                     port_req    <= 5'b00000;
                     route_valid <= 1'b0;
                     state       <= IDLE;
                  end
                  default: state <= IDLE;
               endcase
            end else begin
               proto_err <= 1'b1;
            end
         end else if (cfg_apply) begin
            rxy     <= cfg_rxy;
            cx      <= cfg_cx;
            cur     <= cfg_cur;
            dr      <= cfg_dr;
            cfg_ack <= 1'b1;
         end

         // Registered ready: flits are held off next cycle while a config
         // request is pending in IDLE and has not been served.
         in_ready <= ~(nxt_idle & cfg_we & ~cfg_apply & ~cfg_ack);
      end
   end

endmodule

// File: tb/tb_lbdr_dr.sv
// tb/tb_lbdr_dr.sv - directed self-checking bench for lbdr_dr
module tb_lbdr_dr;

   localparam logic [2:0] HDR = 3'b001;
   localparam logic [2:0] PLD = 3'b010;
   localparam logic [2:0] TL  = 3'b100;

   logic       clk;
   logic       rst;
   logic       cfg_we;
   logic [7:0] cfg_rxy;
   logic [3:0] cfg_cx;
   logic [3:0] cfg_cur;
   logic [3:0] cfg_dr;
   logic       cfg_ack;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] flit_id;
   logic [3:0] dst_addr;
   logic [4:0] port_req;
   logic       route_valid;
   logic       route_err;
   logic       proto_err;

   logic       b_cfg_ack;
   logic       b_in_valid;
   logic       b_in_ready;
   logic [2:0] b_flit_id;
   logic [5:0] b_dst_addr;
   logic [4:0] b_port_req;
   logic       b_route_valid;
   logic       b_route_err;
   logic       b_proto_err;

   int total;
   int bad;

   lbdr_dr dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx), .cfg_cur(cfg_cur), .cfg_dr(cfg_dr),
      .cfg_ack(cfg_ack),
      .in_valid(in_valid), .in_ready(in_ready), .flit_id(flit_id), .dst_addr(dst_addr),
      .port_req(port_req), .route_valid(route_valid), .route_err(route_err), .proto_err(proto_err)
   );

   lbdr_dr #(.XW(3), .YW(3), .CUR_RST(6'd27)) dut_b (
      .clk(clk), .rst(rst),
      .cfg_we(1'b0), .cfg_rxy(8'h00), .cfg_cx(4'h0), .cfg_cur(6'd0), .cfg_dr(4'h0),
      .cfg_ack(b_cfg_ack),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .flit_id(b_flit_id), .dst_addr(b_dst_addr),
      .port_req(b_port_req), .route_valid(b_route_valid), .route_err(b_route_err),
      .proto_err(b_proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; returns 1ns after the rising edge so outputs are settled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] id, input logic [3:0] dst);
      in_valid = 1'b1;
      flit_id  = id;
      dst_addr = dst;
      step();
      in_valid = 1'b0;
   endtask

   task automatic cfg_write(input logic [7:0] rxy, input logic [3:0] cx,
                            input logic [3:0] cur, input logic [3:0] dr);
      logic seen;
      seen    = 1'b0;
      cfg_we  = 1'b1;
      cfg_rxy = rxy;
      cfg_cx  = cx;
      cfg_cur = cur;
      cfg_dr  = dr;
      for (int i = 0; i < 8 && !seen; i++) begin
         step();
         if (cfg_ack) seen = 1'b1;
      end
      cfg_we = 1'b0;
      check("cfg_ack_seen", 32'(seen), 32'd1);
   endtask

   logic [3:0] tbl_dst [4];
   logic [4:0] tbl_exp [4];

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; cfg_we = 1'b0; cfg_rxy = 8'h3C; cfg_cx = 4'hF; cfg_cur = 4'd5; cfg_dr = 4'h0;
      in_valid = 1'b0; flit_id = 3'b000; dst_addr = 4'd0;
      b_in_valid = 1'b0; b_flit_id = 3'b000; b_dst_addr = 6'd0;
      step(); step();
      rst = 1'b0;

      // reset state
      check("rst_port_req", 32'(port_req), 32'h00);
      check("rst_route_valid", 32'(route_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_cfg_ack", 32'(cfg_ack), 32'd0);
      check("rst_route_err", 32'(route_err), 32'd0);
      check("rst_proto_err", 32'(proto_err), 32'd0);

      // defaults: dst 0 from cur 5 -> N1&W1, Rwn=1, Rnw=0 -> W
      send(HDR, 4'd0);
      check("w_hdr_port", 32'(port_req), 32'h04);
      check("w_hdr_valid", 32'(route_valid), 32'd1);
      send(PLD, 4'd9);
      check("w_pld_port", 32'(port_req), 32'h04);
      check("w_pld_perr", 32'(proto_err), 32'd0);
      check("w_tl_cycle_port", 32'(port_req), 32'h04);
      send(TL, 4'd0);
      check("w_after_tl_port", 32'(port_req), 32'h00);
      check("w_after_tl_valid", 32'(route_valid), 32'd0);

      // dst == cur -> local
      send(HDR, 4'd5);
      check("l_port", 32'(port_req), 32'h10);
      check("l_valid", 32'(route_valid), 32'd1);
      send(TL, 4'd0);

      // other quadrants with default Rxy=3C (Ren,Res,Rwn,Rws set)
      tbl_dst[0] = 4'd15; tbl_exp[0] = 5'b00010; // S1&E1 -> E via Res
      tbl_dst[1] = 4'd13; tbl_exp[1] = 5'b01000; // S only
      tbl_dst[2] = 4'd1;  tbl_exp[2] = 5'b00001; // N only
      tbl_dst[3] = 4'd2;  tbl_exp[3] = 5'b00010; // N1&E1 -> E via Ren
      for (int i = 0; i < 4; i++) begin
         send(HDR, tbl_dst[i]);
         check($sformatf("tbl%0d_port", i), 32'(port_req), 32'(tbl_exp[i]));
         send(TL, 4'd0);
         check($sformatf("tbl%0d_clear", i), 32'(port_req), 32'h00);
      end

      // deroute: W blocked by Cw=0, Dr=N
      cfg_write(8'h3C, 4'b1011, 4'd5, 4'b0001);
      send(HDR, 4'd4);
      check("dr_port", 32'(port_req), 32'h01);
      check("dr_valid", 32'(route_valid), 32'd1);
      send(TL, 4'd0);
      cfg_write(8'h3C, 4'b1011, 4'd5, 4'b0000);
      send(HDR, 4'd4);
      check("unr_route_err", 32'(route_err), 32'd1);
      check("unr_port", 32'(port_req), 32'h00);
      check("unr_valid", 32'(route_valid), 32'd0);
      send(PLD, 4'd0);
      check("drop_pld_perr", 32'(proto_err), 32'd0);
      check("drop_pld_rerr", 32'(route_err), 32'd0);
      send(TL, 4'd0);
      check("drop_tl_perr", 32'(proto_err), 32'd0);
      send(PLD, 4'd0);
      check("drop_back_idle", 32'(proto_err), 32'd1);
      cfg_write(8'h3C, 4'hF, 4'd5, 4'h0);

      // config during ROUTED waits for the tail
      send(HDR, 4'd0);
      cfg_we = 1'b1; cfg_rxy = 8'h3C; cfg_cx = 4'b1011; cfg_cur = 4'd5; cfg_dr = 4'h0;
      step();
      check("hold_ack0", 32'(cfg_ack), 32'd0);
      step();
      check("hold_ack1", 32'(cfg_ack), 32'd0);
      send(PLD, 4'd0);
      check("hold_pld_port", 32'(port_req), 32'h04);
      check("hold_pld_ack", 32'(cfg_ack), 32'd0);
      send(TL, 4'd0);
      check("hold_tl_ack", 32'(cfg_ack), 32'd0);
      check("hold_tl_ready", 32'(in_ready), 32'd0);
      step();
      check("hold_ack_after", 32'(cfg_ack), 32'd1);
      cfg_we = 1'b0;
      send(HDR, 4'd0);
      check("newcfg_route_err", 32'(route_err), 32'd1);
      send(TL, 4'd0);
      cfg_write(8'h3C, 4'hF, 4'd5, 4'h0);

      // protocol errors: PLD in IDLE, HDR during ROUTED
      send(PLD, 4'd0);
      check("idle_pld_perr", 32'(proto_err), 32'd1);
      send(HDR, 4'd0);
      check("hdr1_perr", 32'(proto_err), 32'd0);
      check("hdr1_port", 32'(port_req), 32'h04);
      send(HDR, 4'd5);
      check("hdr2_perr", 32'(proto_err), 32'd1);
      check("hdr2_port", 32'(port_req), 32'h10);
      send(3'b111, 4'd0);
      check("bad_id_perr", 32'(proto_err), 32'd1);
      check("bad_id_port", 32'(port_req), 32'h10);
      send(TL, 4'd0);
      check("hdr2_tl_port", 32'(port_req), 32'h00);

      // reset mid-packet abandons it
      send(HDR, 4'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_port", 32'(port_req), 32'h00);
      send(PLD, 4'd0);
      check("midrst_pld_perr", 32'(proto_err), 32'd1);

      // reset wins over a simultaneous config write
      rst = 1'b1; cfg_we = 1'b1; cfg_cx = 4'h0; cfg_dr = 4'h0;
      step();
      rst = 1'b0; cfg_we = 1'b0;
      check("rstcfg_ack", 32'(cfg_ack), 32'd0);
      send(HDR, 4'd0);
      check("rstcfg_port", 32'(port_req), 32'h04);
      send(TL, 4'd0);

      // 3-bit coordinates: cur {3,3}, dst {7,0} -> S1&W1, Rws=1, Rsw=0 -> W
      b_in_valid = 1'b1; b_flit_id = HDR; b_dst_addr = 6'd56;
      step();
      b_in_valid = 1'b0;
      check("b_sw_port", 32'(b_port_req), 32'h04);
      check("b_sw_valid", 32'(b_route_valid), 32'd1);
      b_in_valid = 1'b1; b_flit_id = TL;
      step();
      b_in_valid = 1'b0;
      check("b_tl_port", 32'(b_port_req), 32'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
